// File: rtl/ahb_fir_regmap_if.sv
// AHB-Lite bus bundle between a master and the FIR register map.
// Handshake: a transfer is accepted when hsel & hready & htrans[1]; hready low stalls the data phase.
interface ahb_fir_regmap_if #(
  parameter int ADDR_W = 6
) ();
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic              hwrite;
  logic [15:0]       hwdata;
  logic [15:0]       hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    output hsel, haddr, htrans, hsize, hwrite, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hsize, hwrite, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_fir_regmap.sv
// AHB-Lite register map for the FIR core: sample, coefficients, NCS flag, status and result.
// Optional overrun detection on sample writes is enabled by defining AHB_OVERRUN_DETECT_EN.
module ahb_fir_regmap #(
  parameter int  NUM_COEFF = 4,
  parameter int  ADDR_W    = 6,
  localparam int CIDX_W    = $clog2(NUM_COEFF)
) (
  input  logic              clk,
  input  logic              n_rst,
  ahb_fir_regmap_if.slave   bus,
  input  logic              modwait,
  input  logic              err,
  input  logic [15:0]       fir_out,
  input  logic [CIDX_W-1:0] coefficient_num,
  output logic [15:0]       sample_data,
  output logic [15:0]       fir_coefficient,
  output logic              data_ready,
  output logic              new_coefficient_set,
  output logic [1:0]        fsm_state
);
  localparam int            IW          = ADDR_W - 1;
  localparam logic [IW-1:0] IDX_SAMPLE  = IW'(2);
  localparam logic [IW-1:0] IDX_COEFF0  = IW'(3);
  localparam logic [IW-1:0] IDX_NCS     = IW'(3 + NUM_COEFF);

  typedef enum logic [1:0] {IDLE = 2'd0, ERR1 = 2'd1, ERR2 = 2'd2} state_t;
  state_t state, state_n;

  logic          hready_int, xfer_valid, bad, overrun, ovr_flag;
  logic [IW-1:0] a_idx, dp_idx;
  logic          dp_valid, dp_write, dp_size, dp_lo;
  logic [15:0]   lane_mask, rd_val, status_q, result_q;
  logic [15:0]   coeff [NUM_COEFF];
  logic          ncs, wr_en, sample_wr, ncs_wr;

  assign a_idx      = bus.haddr[ADDR_W-1:1];
  assign xfer_valid = bus.hsel & hready_int & bus.htrans[1];
  assign bad        = (bus.hsize[2:1] != 2'b00) | (bus.hsize[0] & bus.haddr[0]) |
                      (a_idx > IDX_NCS) | (bus.hwrite & (a_idx < IDX_SAMPLE)) | overrun;

`ifdef AHB_OVERRUN_DETECT_EN
  logic ovr_q;
  assign overrun  = bus.hwrite & (a_idx == IDX_SAMPLE) & (modwait | data_ready);
  assign ovr_flag = ovr_q;
  // A fresh overrun outranks the clear from a sample write committing on the same edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                    ovr_q <= 1'b0;
    else if (xfer_valid & overrun) ovr_q <= 1'b1;
    else if (sample_wr)            ovr_q <= 1'b0;
  end
`else
  assign overrun  = 1'b0;
  assign ovr_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (xfer_valid & bad) state_n = ERR1;
      ERR1:    state_n = ERR2;
      ERR2:    state_n = (xfer_valid & bad) ? ERR1 : IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign hready_int = (state != ERR1);
  assign bus.hready = hready_int;
  assign bus.hresp  = (state != IDLE);
  assign fsm_state  = state;

  // Only good transfers reach a data phase, so errored ones never touch registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_size  <= 1'b0;
      dp_lo    <= 1'b0;
      dp_idx   <= '0;
    end else begin
      dp_valid <= xfer_valid & ~bad;
      if (xfer_valid) begin
        dp_write <= bus.hwrite;
        dp_size  <= bus.hsize[0];
        dp_lo    <= bus.haddr[0];
        dp_idx   <= a_idx;
      end
    end
  end

  always_comb begin
    lane_mask = 16'hFFFF;
    if (!dp_size) lane_mask = dp_lo ? 16'hFF00 : 16'h00FF;
  end

  assign wr_en     = dp_valid & dp_write;
  assign sample_wr = wr_en & (dp_idx == IDX_SAMPLE);
  assign ncs_wr    = wr_en & (dp_idx == IDX_NCS) & lane_mask[0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sample_data <= '0;
      for (int k = 0; k < NUM_COEFF; k++) coeff[k] <= '0;
      ncs         <= 1'b0;
      data_ready  <= 1'b0;
      status_q    <= '0;
      result_q    <= '0;
    end else begin
      status_q <= {6'b0, ovr_flag, err, 7'b0, modwait | ncs};
      result_q <= fir_out;
      if (sample_wr) sample_data <= (sample_data & ~lane_mask) | (bus.hwdata & lane_mask);
      for (int k = 0; k < NUM_COEFF; k++)
        if (wr_en && dp_idx == IDX_COEFF0 + IW'(k))
          coeff[k] <= (coeff[k] & ~lane_mask) | (bus.hwdata & lane_mask);
      // Bus write takes priority over the core's end-of-load clear.
      if (ncs_wr)                                                ncs <= bus.hwdata[0];
      else if (ncs && coefficient_num == CIDX_W'(NUM_COEFF - 1)) ncs <= 1'b0;
      if (sample_wr)    data_ready <= 1'b1;
      else if (modwait) data_ready <= 1'b0;
    end
  end

  assign new_coefficient_set = ncs;

  always_comb begin
    rd_val = '0;
    if (dp_idx == IW'(0))            rd_val = status_q;
    else if (dp_idx == IW'(1))       rd_val = result_q;
    else if (dp_idx == IDX_SAMPLE)   rd_val = sample_data;
    else if (dp_idx == IDX_NCS)      rd_val = {15'b0, ncs};
    for (int k = 0; k < NUM_COEFF; k++)
      if (dp_idx == IDX_COEFF0 + IW'(k)) rd_val = coeff[k];
  end

  assign bus.hrdata = (dp_valid & ~dp_write) ? (rd_val & lane_mask) : 16'h0000;

  always_comb begin
    fir_coefficient = '0;
    for (int k = 0; k < NUM_COEFF; k++)
      if (coefficient_num == CIDX_W'(k)) fir_coefficient = coeff[k];
  end
endmodule

// File: tb/tb_ahb_fir_regmap.sv
// Scoreboard bench for ahb_fir_regmap (NUM_COEFF = 8): directed cases, then randomized bus traffic.
// Each bus response is predicted from a map-level model and checked by an independent monitor.
module tb_ahb_fir_regmap;
  localparam int NC = 8;
  localparam int AW = 6;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          modwait = 1'b0;
  logic          err = 1'b0;
  logic [15:0]   fir_out = 16'h0;
  logic [CW-1:0] coefficient_num = '0;
  logic [15:0]   sample_data, fir_coefficient;
  logic          data_ready, new_coefficient_set;
  logic [1:0]    fsm_state;

  ahb_fir_regmap_if #(.ADDR_W(AW)) bus ();

  ahb_fir_regmap #(.NUM_COEFF(NC), .ADDR_W(AW)) dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .bus                 (bus),
    .modwait             (modwait),
    .err                 (err),
    .fir_out             (fir_out),
    .coefficient_num     (coefficient_num),
    .sample_data         (sample_data),
    .fir_coefficient     (fir_coefficient),
    .data_ready          (data_ready),
    .new_coefficient_set (new_coefficient_set),
    .fsm_state           (fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  // Entry: {error expected, read data checked, read data}
  logic [17:0] exp_q[$];

  logic [15:0] m_sample, m_fir;
  logic [15:0] m_coeff [NC];
  logic        m_ncs, m_dr, m_err, m_ovr;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sample = '0;
    for (int k = 0; k < NC; k++) m_coeff[k] = '0;
    m_ncs = 1'b0;
    m_dr  = 1'b0;
    m_ovr = 1'b0;
  endtask

  function automatic logic [15:0] lane_of(input logic [5:0] a, input logic [2:0] sz);
    if (sz == 3'd1) return 16'hFFFF;
    return a[0] ? 16'hFF00 : 16'h00FF;
  endfunction

  // Register contents by halfword index of the map.
  function automatic logic [15:0] model_reg(input int idx);
    if (idx == 0)       return {6'b0, m_ovr, m_err, 7'b0, modwait | m_ncs};
    if (idx == 1)       return m_fir;
    if (idx == 2)       return m_sample;
    if (idx == 3 + NC)  return {15'b0, m_ncs};
    if (idx >= 3 && idx < 3 + NC) return m_coeff[idx-3];
    return 16'h0;
  endfunction

  function automatic logic is_bad(input logic [5:0] a, input logic [2:0] sz, input logic wr);
    int ba;
    logic b;
    ba = int'(a);
    b = (sz > 3'd1) || (sz == 3'd1 && a[0]) || (ba >= 6 + 2*NC + 2) || (wr && ba < 4);
`ifdef AHB_OVERRUN_DETECT_EN
    if (wr && ba / 2 == 2 && (modwait || m_dr)) b = 1'b1;
`endif
    return b;
  endfunction

  task automatic model_write(input logic [5:0] a, input logic [15:0] m, input logic [15:0] d);
    int idx;
    idx = int'(a) / 2;
    if (idx == 2) begin
      m_sample = (m_sample & ~m) | (d & m);
      m_dr  = 1'b1;
      m_ovr = 1'b0;
    end else if (idx >= 3 && idx < 3 + NC) begin
      m_coeff[idx-3] = (m_coeff[idx-3] & ~m) | (d & m);
    end else if (idx == 3 + NC && m[0]) begin
      m_ncs = d[0];
    end
  endtask

  // Called just after a rising edge; returns just after the edge ending the data phase.
  task automatic xfer(input logic [5:0] a, input logic [2:0] sz, input logic wr, input logic [15:0] d);
    logic        bad;
    logic [15:0] m, rv;
    bad = is_bad(a, sz, wr);
    m   = lane_of(a, sz);
    rv  = model_reg(int'(a) / 2) & m;
    exp_q.push_back({bad, ~wr & ~bad, rv});
`ifdef AHB_OVERRUN_DETECT_EN
    if (wr && int'(a) / 2 == 2 && (modwait || m_dr)) m_ovr = 1'b1;
`endif
    if (!bad && wr) model_write(a, m, d);
    bus.hsel = 1'b1; bus.haddr = a; bus.htrans = 2'd2; bus.hsize = sz; bus.hwrite = wr;
    @(posedge clk) #1;
    bus.hsel = 1'b0; bus.htrans = 2'd0; bus.hwdata = d;
    @(posedge clk) #1;
  endtask

  task automatic check_core();
    @(negedge clk);
    chk("sample_data", sample_data, m_sample);
    chk1("data_ready", data_ready, m_dr);
    chk1("new_coefficient_set", new_coefficient_set, m_ncs);
    chk("fir_coefficient", fir_coefficient, m_coeff[coefficient_num]);
    @(posedge clk) #1;
  endtask

  task automatic pulse_modwait();
    modwait = 1'b1;
    @(posedge clk) #1;
    modwait = 1'b0;
    m_dr = 1'b0;
  endtask

  task automatic set_core();
    err     = 1'($urandom_range(0, 1));
    fir_out = 16'($urandom);
    @(posedge clk) #1;
    m_err = err;
    m_fir = fir_out;
  endtask

  // Monitor: pops one expectation per accepted transfer and checks its data-phase response.
  initial begin : monitor
    logic        dp_pend, err2_pend;
    logic [17:0] e;
    dp_pend = 1'b0;
    err2_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        dp_pend = 1'b0;
        err2_pend = 1'b0;
        exp_q.delete();
      end else begin
        if (err2_pend) begin
          chk1("err2_hready", bus.hready, 1'b1);
          chk1("err2_hresp", bus.hresp, 1'b1);
          err2_pend = 1'b0;
        end else if (dp_pend) begin
          dp_pend = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow: got response with empty queue expected none");
          end else begin
            e = exp_q.pop_front();
            if (e[17]) begin
              chk1("err1_hready", bus.hready, 1'b0);
              chk1("err1_hresp", bus.hresp, 1'b1);
              err2_pend = 1'b1;
            end else begin
              chk1("ok_hready", bus.hready, 1'b1);
              chk1("ok_hresp", bus.hresp, 1'b0);
              if (e[16]) chk("hrdata", bus.hrdata, e[15:0]);
            end
          end
        end
        if (bus.hsel && bus.hready && bus.htrans[1]) dp_pend = 1'b1;
      end
    end
  end

  initial begin
    logic [5:0]  a;
    logic [2:0]  sz;
    logic        wr;
    int          r;
    bus.hsel = 1'b0; bus.haddr = '0; bus.htrans = 2'd0; bus.hsize = 3'd1;
    bus.hwrite = 1'b0; bus.hwdata = 16'h0;
    model_reset();
    m_err = 1'b0;
    m_fir = 16'h0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hrdata", bus.hrdata, 16'h0);
    chk1("rst_hready", bus.hready, 1'b1);
    chk1("rst_hresp", bus.hresp, 1'b0);
    chk("rst_sample", sample_data, 16'h0);
    chk1("rst_data_ready", data_ready, 1'b0);
    chk1("rst_ncs", new_coefficient_set, 1'b0);
    chk("rst_fir_coeff", fir_coefficient, 16'h0);
    chk("rst_fsm", {14'b0, fsm_state}, 16'h0);
    @(posedge clk) #3 n_rst = 1'b1;
    @(posedge clk) #1;

    // Status read, sample write and data_ready handshake
    xfer(6'h00, 3'd1, 1'b0, 16'h0);
    xfer(6'h04, 3'd1, 1'b1, 16'hBEEF);
    check_core();
    check_core();
    pulse_modwait();
    check_core();

    // Byte lanes over a coefficient
    xfer(6'h06, 3'd1, 1'b1, 16'h1234);
    xfer(6'h07, 3'd0, 1'b1, 16'hAB00);
    xfer(6'h06, 3'd1, 1'b0, 16'h0);
    xfer(6'h07, 3'd0, 1'b0, 16'h0);
    xfer(6'h06, 3'd0, 1'b0, 16'h0);

    // Fill all taps, set NCS, sweep the core's coefficient index
    for (int k = 1; k < NC - 1; k++) xfer(6'(6 + 2*k), 3'd1, 1'b1, 16'($urandom));
    xfer(6'h14, 3'd1, 1'b1, 16'h55AA);
    xfer(6'h16, 3'd1, 1'b1, 16'h0001);
    xfer(6'h00, 3'd1, 1'b0, 16'h0);
    for (int k = 0; k < NC; k++) begin
      coefficient_num = CW'(k);
      check_core();
      if (k == NC - 1) m_ncs = 1'b0;
    end
    coefficient_num = '0;
    check_core();
    xfer(6'h16, 3'd1, 1'b0, 16'h0);

    // Error responses, including back-to-back errors
    xfer(6'h02, 3'd1, 1'b1, 16'hFFFF);
    xfer(6'h05, 3'd1, 1'b1, 16'hFFFF);
    xfer(6'h04, 3'd2, 1'b1, 16'h0F0F);
    xfer(6'h18, 3'd1, 1'b0, 16'h0);
    xfer(6'h04, 3'd1, 1'b0, 16'h0);
    xfer(6'h06, 3'd1, 1'b0, 16'h0);
    check_core();

    // Address phase presented while hready is low is ignored
    exp_q.push_back({1'b1, 1'b0, 16'h0});
    bus.hsel = 1'b1; bus.haddr = 6'h02; bus.htrans = 2'd2; bus.hsize = 3'd1; bus.hwrite = 1'b1;
    @(posedge clk) #1;
    bus.haddr = 6'h04; bus.hwdata = 16'h1111;
    @(posedge clk) #1;
    bus.hsel = 1'b0; bus.htrans = 2'd0;
    check_core();
    xfer(6'h04, 3'd1, 1'b0, 16'h0);

`ifdef AHB_OVERRUN_DETECT_EN
    modwait = 1'b1;
    xfer(6'h04, 3'd1, 1'b1, 16'h7777);
    xfer(6'h00, 3'd1, 1'b0, 16'h0);
    modwait = 1'b0;
    m_dr = 1'b0;
    check_core();
`endif

    // Reset in the middle of an error response
    exp_q.push_back({1'b1, 1'b0, 16'h0});
    bus.hsel = 1'b1; bus.haddr = 6'h02; bus.htrans = 2'd2; bus.hsize = 3'd1; bus.hwrite = 1'b1;
    @(posedge clk) #1;
    bus.hsel = 1'b0; bus.htrans = 2'd0;
    n_rst = 1'b0;
    #1;
    chk1("midrst_hready", bus.hready, 1'b1);
    chk1("midrst_hresp", bus.hresp, 1'b0);
    chk("midrst_fsm", {14'b0, fsm_state}, 16'h0);
    chk("midrst_sample", sample_data, 16'h0);
    @(posedge clk) #3 n_rst = 1'b1;
    @(posedge clk) #1;
    model_reset();
    check_core();
    xfer(6'h06, 3'd1, 1'b0, 16'h0);

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0) pulse_modwait();
      else if (r == 1) set_core();
      a = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 23));
      r = int'($urandom_range(0, 7));
      sz = (r < 3) ? 3'd0 : (r < 7) ? 3'd1 : 3'($urandom_range(2, 7));
      if (sz == 3'd1 && $urandom_range(0, 7) != 0) a[0] = 1'b0;
      wr = 1'($urandom_range(0, 1));
      xfer(a, sz, wr, 16'($urandom));
      if ($urandom_range(0, 7) == 0) check_core();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drain", 16'(exp_q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
